// File: rtl/osecpu_seg_monitor_if.sv
// CPU-side register taps and 7-segment display outputs of the OSECPU segment monitor.
interface osecpu_seg_monitor_if;
   logic [31:0] dr;
   logic [15:0] pc;
   logic [7:0]  cr;
   logic [1:0]  mode;
   logic [7:0]  seg;
   logic [3:0]  segsel;
   logic        halted;

   modport master (output dr, pc, cr, mode, input seg, segsel, halted);
   modport slave  (input dr, pc, cr, mode, output seg, segsel, halted);
endinterface

// File: rtl/osecpu_seg_monitor.sv
// 4-digit multiplexed hex display of OSECPU dr/pc with per-round coherent snapshots
// and a halt freeze so the final result stays readable.
module osecpu_seg_monitor #(
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 500,
   parameter int ROT_ROUNDS = 1000,
   parameter int HLT_BIT    = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   osecpu_seg_monitor_if.slave  bus
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int ROT_W = (ROT_ROUNDS > 2) ? $clog2(ROT_ROUNDS) : 1;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0] cnt;
   logic [ROT_W-1:0] rot;
   logic [1:0]       idx;
   logic             active;
   logic             page;
   logic             halted_r;
   logic             slot_vld_p1;
   logic [31:0]      dr_s;
   logic [15:0]      pc_s;
   logic [7:0]       seg_r;
   logic [3:0]       segsel_r;

   logic             tick;
   logic             round_start;
   logic             hlt_now;
   logic [15:0]      window;
   logic [3:0]       nib;
   logic [3:0]       en;
   logic             dp_on;

   always_comb begin
      tick        = (cnt == CNT_W'(SCAN_DIV - 1));
      round_start = tick && active && (idx == 2'd3);
      hlt_now     = bus.cr[HLT_BIT] && !halted_r;
      window      = dr_s[15:0];
      case (bus.mode)
         2'd0:    window = dr_s[15:0];
         2'd1:    window = dr_s[31:16];
         2'd2:    window = pc_s;
         default: window = page ? dr_s[31:16] : dr_s[15:0];
      endcase
      nib   = window[{idx, 2'b00} +: 4];
      en    = ~(4'b0001 << idx);
      dp_on = halted_r || ((bus.mode == 2'd3) && page && (idx == 2'd3));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         rot         <= '0;
         idx         <= 2'd0;
         active      <= 1'b0;
         page        <= 1'b0;
         halted_r    <= 1'b0;
         slot_vld_p1 <= 1'b0;
         dr_s        <= '0;
         pc_s        <= '0;
         seg_r       <= 8'hFF;
         segsel_r    <= 4'hF;
      end else begin
         cnt         <= tick ? '0 : cnt + 1'b1;
         slot_vld_p1 <= tick;
         // The first tick after reset only arms the scan so it starts at digit 0.
         if (tick) begin
            if (!active) active <= 1'b1;
            else         idx    <= idx + 2'd1;
         end
         if (hlt_now) begin
            halted_r <= 1'b1;
            dr_s     <= bus.dr;
            pc_s     <= bus.pc;
         end else if (round_start && !halted_r) begin
            dr_s <= bus.dr;
            pc_s <= bus.pc;
         end
         if (round_start) begin
            if (rot == ROT_W'(ROT_ROUNDS - 1)) begin
               rot  <= '0;
               page <= ~page;
            end else begin
               rot <= rot + 1'b1;
            end
         end
         // ---- p1: one cycle after tick, idx and snapshot are settled for the new slot
         if (slot_vld_p1) begin
            seg_r    <= {~dp_on, hex_decode(nib)};
            segsel_r <= (BLANK_CYC == 0) ? en : 4'hF;
         end else if (active && (cnt == CNT_W'(BLANK_CYC))) begin
            segsel_r <= en;
         end
      end
   end

   assign bus.seg    = seg_r;
   assign bus.segsel = segsel_r;
   assign bus.halted = halted_r;

endmodule
